axis_pkt_arbiter: RTL
=====================

AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
REQ-001 The block SHALL have parameter AXI_DATA_WIDTH, default 32, meaning data width in bits of every stream port.
REQ-002 The block SHALL have parameter NUM_INPUTS, default 4, meaning number of requesting input streams (legal range 2..16).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge clk.
REQ-004 The block SHALL have port rst, input, 1, meaning the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port s_valid, input, NUM_INPUTS, meaning per-input beat valid.
REQ-006 The block SHALL have port s_last, input, NUM_INPUTS, meaning per-input end-of-packet marker.
REQ-007 The block SHALL have port s_data, input, NUM_INPUTS*AXI_DATA_WIDTH, meaning per-input data, with input i at bits [i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH].
REQ-008 The block SHALL have port s_ready, output, NUM_INPUTS, meaning per-input ready.
REQ-009 The block SHALL have ports m_valid, m_last and m_data (output, 1/1/AXI_DATA_WIDTH) and m_ready (input, 1), meaning the shared output stream.
REQ-010 The block SHALL have port grant, output, NUM_INPUTS, meaning the one-hot currently owning input (all zero when none).
REQ-011 The block SHALL have port busy, output, 1, meaning a packet is in progress (state BUSY).

Function
REQ-012 A beat SHALL transfer on any port only in a cycle where valid and ready are both 1 at the rising clk edge.
REQ-013 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-014 In IDLE, when s_valid is nonzero, the FSM SHALL select the first requesting input at or after the round-robin pointer rr_ptr (wrapping NUM_INPUTS-1 -> 0), register it as the owner, and enter BUSY on the next edge.
REQ-015 In IDLE, grant SHALL be 0, s_ready SHALL be all 0, and m_valid SHALL be 0.
REQ-016 In BUSY with owner k, m_valid, m_last and m_data SHALL equal s_valid[k], s_last[k] and s_data[k] combinationally, s_ready[k] SHALL equal m_ready, and every other s_ready bit SHALL be 0.
REQ-017 In BUSY, a handshake with m_last=1 SHALL return the FSM to IDLE and set rr_ptr to (k+1) mod NUM_INPUTS.
REQ-018 Ownership SHALL be held for the whole packet, regardless of s_valid[k] deasserting mid-packet or of other inputs requesting.
REQ-019 Latency from s_valid rising in IDLE to m_valid SHALL be exactly 1 cycle, with one IDLE bubble between consecutive packets.
REQ-020 A single-beat packet (s_last=1 on the first beat) SHALL occupy exactly one BUSY cycle when m_ready=1.
REQ-021 While m_ready=0 in BUSY, the owner's beat SHALL stall with no data loss, and the state and owner SHALL be unchanged.
REQ-022 rr_ptr and the owner index SHALL each be $clog2(NUM_INPUTS) bits wide, and wrap-around SHALL be explicit for non-power-of-2 NUM_INPUTS.

Reset
REQ-023 While rst=1, the FSM SHALL be IDLE, rr_ptr SHALL be 0, grant, busy, s_ready and m_valid SHALL be 0, and pkt_cnt (if present) SHALL be 0.
REQ-024 rst asserted mid-packet SHALL abort the packet without emitting a beat; the input must resend a full packet.
REQ-025 The first arbitration after reset SHALL favour input 0.

Configuration
REQ-026 With macro AXIS_ARB_PKT_CNT_EN defined, the block SHALL add output pkt_cnt, 16 bits, which increments by 1 on every m_last handshake and wraps from 0xFFFF to 0x0000.
REQ-027 With AXIS_ARB_PKT_CNT_EN undefined, the block SHALL have no pkt_cnt port, no pkt_cnt logic, and otherwise identical behaviour.

Verification
REQ-028 The bench SHALL cover: all 4 inputs send 3-beat packets simultaneously from reset, m_ready=1 -> packets output in order 0,1,2,3 with grant one-hot 0001,0010,0100,1000 and one bubble between packets.
REQ-029 The bench SHALL cover: input 2 sends 0xA0..0xA4 (5 beats) with m_ready toggling 1,0 every cycle -> m_data sequence is exactly 0xA0..0xA4, m_last only on 0xA4, and input 2 keeps ownership throughout.
REQ-030 The bench SHALL cover: input 1 holding ownership drops s_valid for 3 cycles mid-packet while input 3 requests -> m_valid=0 for those 3 cycles, grant stays 0010, and input 3 is granted only after input 1's last beat.
REQ-031 The bench SHALL cover: input 0 alone sends back-to-back 1-beat packets -> a grant every 2 cycles, m_valid pattern 1,0,1,0.
REQ-032 The bench SHALL cover: rst pulsed for 1 cycle on beat 2 of a 4-beat packet from input 3 -> next cycle busy=0, grant=0, and the next arbitration with inputs 0 and 3 requesting grants input 0.
REQ-033 The bench SHALL cover, with AXIS_ARB_PKT_CNT_EN defined: pkt_cnt preloaded near wrap by sending 65537 single-beat packets -> pkt_cnt reads 0x0001.

Source files
------------

// File: rtl/axis_pkt_arbiter.sv
// Round-robin packet arbiter: multiplexes NUM_INPUTS AXI-Stream inputs onto one output, one whole packet at a time.
// Optional feature: define AXIS_ARB_PKT_CNT_EN to add the 16-bit completed-packet counter output pkt_cnt.
module axis_pkt_arbiter #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int NUM_INPUTS     = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_INPUTS-1:0]                s_valid,
   input  logic [NUM_INPUTS-1:0]                s_last,
   input  logic [NUM_INPUTS*AXI_DATA_WIDTH-1:0] s_data,
   output logic [NUM_INPUTS-1:0]                s_ready,
   output logic                                 m_valid,
   output logic                                 m_last,
   output logic [AXI_DATA_WIDTH-1:0]            m_data,
   input  logic                                 m_ready,
   output logic [NUM_INPUTS-1:0]                grant,
   output logic                                 busy
`ifdef AXIS_ARB_PKT_CNT_EN
   ,
   output logic [15:0]                          pkt_cnt
`endif
);

   localparam int IDX_W = $clog2(NUM_INPUTS);
   localparam int CW    = IDX_W + 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          owner_q, owner_d;
   logic [IDX_W-1:0]          rrPtr_q, rrPtr_d;
   logic [IDX_W-1:0]          pick;
   logic [IDX_W-1:0]          ownerNext;
   logic [IDX_W:0]            cand;
   logic                      found;
   logic                      active;
   logic                      lastBeat;
   logic [AXI_DATA_WIDTH-1:0] dataArr [NUM_INPUTS];

   for (genvar g = 0; g < NUM_INPUTS; g++) begin : gSlice
      assign dataArr[g] = s_data[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
   end

   // Search from the pointer upward; the extra bit lets the wrap work for any NUM_INPUTS.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      cand  = '0;
      for (int off = 0; off < NUM_INPUTS; off++) begin
         cand = {1'b0, rrPtr_q} + CW'(off);
         if (cand >= CW'(NUM_INPUTS)) begin
            cand = cand - CW'(NUM_INPUTS);
         end
         if (!found && s_valid[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            pick  = cand[IDX_W-1:0];
         end
      end
   end

   assign ownerNext = (owner_q == IDX_W'(NUM_INPUTS-1)) ? '0 : owner_q + 1'b1;

   // Outputs are gated by rst so an in-flight packet is dropped during the reset cycle.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rrPtr_d  = rrPtr_q;
      active   = (state_q == BUSY) && !rst;
      busy     = active;
      grant    = '0;
      s_ready  = '0;
      m_valid  = 1'b0;
      m_last   = 1'b0;
      m_data   = dataArr[owner_q];
      lastBeat = 1'b0;
      if (active) begin
         grant[owner_q]   = 1'b1;
         s_ready[owner_q] = m_ready;
         m_valid          = s_valid[owner_q];
         m_last           = s_last[owner_q];
      end
      lastBeat = m_valid && m_ready && m_last;
      case (state_q)
         IDLE: begin
            if (found) begin
               owner_d = pick;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (lastBeat) begin
               state_d = IDLE;
               rrPtr_d = ownerNext;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         rrPtr_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rrPtr_q <= rrPtr_d;
      end
   end

`ifdef AXIS_ARB_PKT_CNT_EN
   logic [15:0] pktCnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pktCnt_q <= '0;
      end else if (lastBeat) begin
         pktCnt_q <= pktCnt_q + 16'd1;
      end
   end

   assign pkt_cnt = pktCnt_q;
`endif

endmodule
